sccb_reg_responder: RTL
=======================

# sccb_reg_responder

SCCB responder that models the OV7670 register file on the far end of the camera configuration bus. It decodes 3-phase write and 2-phase-write/2-phase-read transactions from the configuration initiator, stores written bytes in a 256x8 register file, and returns register contents on reads. It sits in the gesture-detection simulation bench and in loopback builds, standing in for the sensor. It also reports every accepted write on a strobe port, so the bench can check the configuration sequence.

## Interface
- DEV_ID, 8'h42: 7-bit SCCB write address in bits [7:1]. Bit 0 of the received ID byte selects read (1) or write (0).
- PID_VAL, 8'h76 / VER_VAL, 8'h73 / MIDH_VAL, 8'h7F / MIDL_VAL, 8'hA2: reset contents of read-only registers 0x0A, 0x0B, 0x1C and 0x1D.

Ports:
- iCLK  in  1  system clock; must be at least 16x the SCL frequency.
- iRST_N  in  1  synchronous, active-low reset.
- iSCL  in  1  bus clock, asynchronous.
- iSDA  in  1  bus data as seen on the wire, asynchronous.
- oSDA_OE  out  1  1 = pull SDA low (open drain); reset 0.
- oWR_STB  out  1  one-cycle pulse per accepted register write; reset 0.
- oWR_ADDR  out  8  sub-address of the last write; reset 0.
- oWR_DATA  out  8  data of the last write; reset 0.
- oBUSY  out  1  high between START and STOP; reset 0.

## Operation
- iSCL and iSDA each pass through a 2-FF synchronizer, then a 1-cycle delayed copy for edge detection.
- START = SDA falls while SCL is high. STOP = SDA rises while SCL is high. Both are detected in any state.
- A START, including a repeated START, always forces DEV.
- A STOP always forces IDLE.
- Data bits are sampled on the SCL rising edge, MSB first. oSDA_OE changes only on the SCL falling edge.
- States:
  - IDLE: waits for START.
  - DEV: receives the ID byte.
  - DEV_ACK: drives ACK low if ID[7:1] == DEV_ID[7:1]; otherwise goes to IGNORE until STOP.
  - SUB: receives the sub-address into the address pointer.
  - SUB_ACK: drives ACK.
  - WDATA: receives the data byte.
  - WDATA_ACK: drives ACK.
  - RDATA: drives the byte at the pointer, MSB first. A 1 bit releases SDA (oSDA_OE = 0).
  - RD_NA: releases SDA and samples the master's NA/ACK.
- ID byte with bit 0 = 0 goes to SUB. Bit 0 = 1 goes to RDATA, using the pointer left by the previous 2-phase write.
- After WDATA_ACK the responder returns to WDATA for burst bytes. Each burst byte is written to the same pointer unless autoinc is enabled (see Configuration).
- After RD_NA:
  - NA (SDA high): go to IGNORE.
  - ACK (SDA low): load the next byte and go to RDATA.
- Writes to 0x0A, 0x0B, 0x1C and 0x1D are acknowledged and strobed but do not change the register file.
- Write 0x12 with bit 7 = 1 (soft reset): the register file returns to reset contents on the cycle after the strobe. The stored value of 0x12 becomes 0x00.
- Register file reset contents: all 0x00 except the four ID registers.
- Reset mid-transaction: all outputs take their reset values, the register file is reinitialised and the FSM goes to IDLE.

## Timing
- START/STOP detection latency is 3 iCLK cycles from the pin edge: 2 synchronizer stages plus 1 edge stage.
- oWR_STB asserts exactly once per data byte, in the iCLK cycle after the SCL falling edge that ends bit 8 (the start of the ACK slot). oWR_ADDR and oWR_DATA update in that same cycle and hold until the next write.
- oSDA_OE for ACK asserts on the falling edge after bit 8 and deasserts on the following falling edge.
- The read byte is latched from the register file on the falling edge that ends the ACK slot, so a same-transaction write is visible to the next read.
- oBUSY rises with START detection and falls with STOP detection.

## Configuration
- SCCB_RESP_AUTOINC_EN
  - Defined: the pointer increments by 1 (mod 256, 0xFF wraps to 0x00) after every written data byte and after every read byte the master ACKs.
  - Undefined: the pointer stays fixed for the whole transaction.

## Structure
- Package sccb_resp_pkg holds:
  - the state enum;
  - read-only register address constants 0x0A/0x0B/0x1C/0x1D and the COM7 address 0x12;
  - the soft-reset bit index 7.
- Sub-module sccb_pin_sync: 2-FF synchronizer and edge/START/STOP detector, shared with future SCCB blocks.

## Test plan
- 3-phase write 42/3A/0D -> one oWR_STB with ADDR = 0x3A, DATA = 0x0D; ACK low in all three ACK slots.
- 2-phase write 42/1C, STOP, then 43 read with NA -> byte 0x7F on SDA, FSM returns to IDLE after STOP.
- Wrong ID 0x60 -> oSDA_OE stays 0 for the whole transaction; no strobe.
- Write 42/12/80, then read 0x3A -> 0x00 (soft reset cleared the earlier 0x0D); read 0x1D -> 0xA2.
- Burst 42/FF/11/22 with SCCB_RESP_AUTOINC_EN -> 0xFF = 0x11, 0x00 = 0x22. Without the macro -> 0xFF = 0x22.
- iRST_N low during WDATA bit 4 -> no strobe; outputs at reset values; next transaction is accepted normally.

Source files
------------

// File: rtl/sccb_resp_pkg.sv
// Shared types and constants for the SCCB register responder: FSM states,
// read-only/ID register addresses and the COM7 soft-reset control.
package sccb_resp_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_DEV,
      ST_DEV_ACK,
      ST_SUB,
      ST_SUB_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RDATA,
      ST_RD_NA,
      ST_IGNORE
   } state_e;

   localparam logic [7:0] ADDR_PID  = 8'h0A;
   localparam logic [7:0] ADDR_VER  = 8'h0B;
   localparam logic [7:0] ADDR_MIDH = 8'h1C;
   localparam logic [7:0] ADDR_MIDL = 8'h1D;
   localparam logic [7:0] ADDR_COM7 = 8'h12;
   localparam int         SOFT_RST_BIT = 7;

   function automatic logic is_ro(input logic [7:0] addr);
      return (addr == ADDR_PID) || (addr == ADDR_VER) ||
             (addr == ADDR_MIDH) || (addr == ADDR_MIDL);
   endfunction

endpackage

// File: rtl/sccb_pin_sync.sv
// Two-flop synchronizer for SCL/SDA plus registered edge and START/STOP detection.
// All event pulses arrive 3 clk cycles after the pin edge; sda_o is aligned with them.
module sccb_pin_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o,
   output logic sda_o
);

   logic [1:0] scl_sync_q, sda_sync_q;
   logic       scl_dly_q, sda_dly_q;
   logic       scl_rise_q, scl_fall_q, start_q, stop_q;

   // Reset to the idle-bus level so release never looks like a bus event
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_dly_q  <= 1'b1;
         sda_dly_q  <= 1'b1;
         scl_rise_q <= 1'b0;
         scl_fall_q <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
      end else begin
         scl_sync_q <= {scl_sync_q[0], scl_i};
         sda_sync_q <= {sda_sync_q[0], sda_i};
         scl_dly_q  <= scl_sync_q[1];
         sda_dly_q  <= sda_sync_q[1];
         scl_rise_q <= scl_sync_q[1] & ~scl_dly_q;
         scl_fall_q <= ~scl_sync_q[1] & scl_dly_q;
         start_q    <= scl_sync_q[1] & scl_dly_q & sda_dly_q & ~sda_sync_q[1];
         stop_q     <= scl_sync_q[1] & scl_dly_q & ~sda_dly_q & sda_sync_q[1];
      end
   end

   assign scl_rise_o = scl_rise_q;
   assign scl_fall_o = scl_fall_q;
   assign start_o    = start_q;
   assign stop_o     = stop_q;
   assign sda_o      = sda_dly_q;

endmodule

// File: rtl/sccb_reg_responder.sv
// SCCB responder standing in for the OV7670 register file (256x8, four read-only ID regs).
// Define SCCB_RESP_AUTOINC_EN to advance the pointer after each written or ACKed read byte.
module sccb_reg_responder
   import sccb_resp_pkg::*;
#(
   parameter logic [7:0] DEV_ID   = 8'h42,
   parameter logic [7:0] PID_VAL  = 8'h76,
   parameter logic [7:0] VER_VAL  = 8'h73,
   parameter logic [7:0] MIDH_VAL = 8'h7F,
   parameter logic [7:0] MIDL_VAL = 8'hA2
) (
   input  logic       iCLK,
   input  logic       iRST_N,
   input  logic       iSCL,
   input  logic       iSDA,
   output logic       oSDA_OE,
   output logic       oWR_STB,
   output logic [7:0] oWR_ADDR,
   output logic [7:0] oWR_DATA,
   output logic       oBUSY
);

`ifdef SCCB_RESP_AUTOINC_EN
   localparam logic AUTOINC = 1'b1;
`else
   localparam logic AUTOINC = 1'b0;
`endif

   logic       scl_rise, scl_fall, start, stop, sda;
   state_e     state_q;
   logic [3:0] cnt_q;
   logic [7:0] shift_q, tx_q, ptr_q;
   logic       rw_q, nack_q;
   logic       sda_oe_q, wr_stb_q, busy_q;
   logic [7:0] wr_addr_q, wr_data_q;
   logic [7:0] regs_q [256];
   logic [7:0] ptr_d, rd_byte;
   logic       soft_rst;

   sccb_pin_sync u_pin_sync (
      .clk_i      (iCLK),
      .rst_ni     (iRST_N),
      .scl_i      (iSCL),
      .sda_i      (iSDA),
      .scl_rise_o (scl_rise),
      .scl_fall_o (scl_fall),
      .start_o    (start),
      .stop_o     (stop),
      .sda_o      (sda)
   );

   function automatic logic [7:0] init_val(input logic [7:0] addr);
      case (addr)
         ADDR_PID:  init_val = PID_VAL;
         ADDR_VER:  init_val = VER_VAL;
         ADDR_MIDH: init_val = MIDH_VAL;
         ADDR_MIDL: init_val = MIDL_VAL;
         default:   init_val = 8'h00;
      endcase
   endfunction

   assign ptr_d    = AUTOINC ? ptr_q + 8'd1 : ptr_q;
   // On a master ACK the next byte comes from the advanced pointer
   assign rd_byte  = (state_q == ST_RD_NA) ? regs_q[ptr_d] : regs_q[ptr_q];
   assign soft_rst = wr_stb_q && (wr_addr_q == ADDR_COM7) && wr_data_q[SOFT_RST_BIT];

   always_ff @(posedge iCLK) begin
      if (!iRST_N || soft_rst) begin
         for (int i = 0; i < 256; i++) regs_q[i] <= init_val(8'(i));
      end else if (wr_stb_q && !is_ro(wr_addr_q)) begin
         regs_q[wr_addr_q] <= wr_data_q;
      end
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 4'd0;
         shift_q   <= 8'h00;
         tx_q      <= 8'h00;
         ptr_q     <= 8'h00;
         rw_q      <= 1'b0;
         nack_q    <= 1'b1;
         sda_oe_q  <= 1'b0;
         wr_stb_q  <= 1'b0;
         wr_addr_q <= 8'h00;
         wr_data_q <= 8'h00;
         busy_q    <= 1'b0;
      end else begin
         wr_stb_q <= 1'b0;
         if (start) begin
            state_q  <= ST_DEV;
            cnt_q    <= 4'd0;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b1;
         end else if (stop) begin
            state_q  <= ST_IDLE;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
         end else if (scl_rise) begin
            case (state_q)
               ST_DEV, ST_SUB, ST_WDATA, ST_RDATA: begin
                  shift_q <= {shift_q[6:0], sda};
                  cnt_q   <= cnt_q + 4'd1;
               end
               ST_RD_NA: nack_q <= sda;
               default: ;
            endcase
         end else if (scl_fall) begin
            case (state_q)
               ST_DEV: if (cnt_q == 4'd8) begin
                  rw_q <= shift_q[0];
                  if (shift_q[7:1] == DEV_ID[7:1]) begin
                     state_q  <= ST_DEV_ACK;
                     sda_oe_q <= 1'b1;
                  end else begin
                     state_q <= ST_IGNORE;
                  end
               end
               ST_DEV_ACK: begin
                  cnt_q <= 4'd0;
                  if (rw_q) begin
                     state_q  <= ST_RDATA;
                     tx_q     <= {rd_byte[6:0], 1'b0};
                     sda_oe_q <= ~rd_byte[7];
                  end else begin
                     state_q  <= ST_SUB;
                     sda_oe_q <= 1'b0;
                  end
               end
               ST_SUB: if (cnt_q == 4'd8) begin
                  ptr_q    <= shift_q;
                  sda_oe_q <= 1'b1;
                  state_q  <= ST_SUB_ACK;
               end
               ST_SUB_ACK, ST_WDATA_ACK: begin
                  sda_oe_q <= 1'b0;
                  cnt_q    <= 4'd0;
                  state_q  <= ST_WDATA;
               end
               ST_WDATA: if (cnt_q == 4'd8) begin
                  sda_oe_q  <= 1'b1;
                  wr_stb_q  <= 1'b1;
                  wr_addr_q <= ptr_q;
                  wr_data_q <= shift_q;
                  ptr_q     <= ptr_d;
                  state_q   <= ST_WDATA_ACK;
               end
               ST_RDATA: begin
                  if (cnt_q == 4'd8) begin
                     sda_oe_q <= 1'b0;
                     state_q  <= ST_RD_NA;
                  end else begin
                     sda_oe_q <= ~tx_q[7];
                     tx_q     <= {tx_q[6:0], 1'b0};
                  end
               end
               ST_RD_NA: begin
                  cnt_q <= 4'd0;
                  if (nack_q) begin
                     state_q <= ST_IGNORE;
                  end else begin
                     ptr_q    <= ptr_d;
                     tx_q     <= {rd_byte[6:0], 1'b0};
                     sda_oe_q <= ~rd_byte[7];
                     state_q  <= ST_RDATA;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign oSDA_OE  = sda_oe_q;
   assign oWR_STB  = wr_stb_q;
   assign oWR_ADDR = wr_addr_q;
   assign oWR_DATA = wr_data_q;
   assign oBUSY    = busy_q;

endmodule
